// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch-queue handshake bundle: PC in, imem req/rsp, decode out, flush
interface if_fetch_queue_if #(
    parameter int AW = 32
);
    logic [AW-1:0] pc_i;
    logic          pc_valid_i;
    logic          pc_ready_o;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_gnt_i;
    logic          imem_rvalid_i;
    logic [31:0]   imem_rdata_i;
    logic          inst_valid_o;
    logic [31:0]   inst_o;
    logic [AW-1:0] inst_pc_o;
    logic          inst_ready_i;
    logic          flush_i;

    modport slave (
        input  pc_i, pc_valid_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
               inst_ready_i, flush_i,
        output pc_ready_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
    );

    modport master (
        output pc_i, pc_valid_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
               inst_ready_i, flush_i,
        input  pc_ready_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o
    );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch queue with in-order imem responses and flush drain
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    if_fetch_queue_if.slave     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] pend_cnt_q, pend_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] discard_cnt_q, discard_cnt_d;
    logic [PW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
    logic [PW-1:0] ff_wr_q, ff_wr_d, ff_rd_q, ff_rd_d;
    logic [AW-1:0] pq_pc_q [DEPTH];
    logic [AW-1:0] pq_pc_d [DEPTH];
    logic [31:0]   ff_inst_q [DEPTH];
    logic [31:0]   ff_inst_d [DEPTH];
    logic [AW-1:0] ff_pc_q [DEPTH];
    logic [AW-1:0] ff_pc_d [DEPTH];

    logic [CW:0]   used;
    logic          credit, req, accept, rsp, push, pop, run;

    assign run    = (state_q == RUN);
    assign used   = {1'b0, pend_cnt_q} + {1'b0, out_cnt_q};
    assign credit = used < (CW+1)'(DEPTH);
    // Gated by rst_n so no request leaks out while reset is held.
    assign req    = rst_n & run & bus.pc_valid_i & credit & ~bus.flush_i;
    assign accept = req & bus.imem_gnt_i;
    // A response with nothing pending is a protocol error and is ignored.
    assign rsp    = bus.imem_rvalid_i & (pend_cnt_q != '0);
    assign push   = rsp & run & ~bus.flush_i;
    assign pop    = (out_cnt_q != '0) & bus.inst_ready_i & run & ~bus.flush_i;

    always_comb begin
        state_d       = state_q;
        pq_wr_d       = pq_wr_q;
        pq_rd_d       = pq_rd_q;
        ff_wr_d       = ff_wr_q;
        ff_rd_d       = ff_rd_q;
        pq_pc_d       = pq_pc_q;
        ff_inst_d     = ff_inst_q;
        ff_pc_d       = ff_pc_q;
        discard_cnt_d = discard_cnt_q;

        if (accept) begin
            pq_pc_d[pq_wr_q] = bus.pc_i;
            pq_wr_d          = pq_wr_q + 1'b1;
        end
        if (rsp) begin
            pq_rd_d = pq_rd_q + 1'b1;
        end
        pend_cnt_d = pend_cnt_q + CW'(accept) - CW'(rsp);

        if (push) begin
            ff_inst_d[ff_wr_q] = bus.imem_rdata_i;
            ff_pc_d[ff_wr_q]   = pq_pc_q[pq_rd_q];
            ff_wr_d            = ff_wr_q + 1'b1;
        end
        if (pop) begin
            ff_rd_d = ff_rd_q + 1'b1;
        end
        out_cnt_d = out_cnt_q + CW'(push) - CW'(pop);

        case (state_q)
            RUN: begin
                if (bus.flush_i) begin
                    out_cnt_d     = '0;
                    ff_wr_d       = '0;
                    ff_rd_d       = '0;
                    // No accept in a flush cycle, so pend_cnt_d is exactly what is still stale.
                    discard_cnt_d = pend_cnt_d;
                    if (pend_cnt_d != '0) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rsp) begin
                    discard_cnt_d = discard_cnt_q - CW'(1);
                    if (discard_cnt_q <= CW'(1)) state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pend_cnt_q    <= '0;
            out_cnt_q     <= '0;
            discard_cnt_q <= '0;
            pq_wr_q       <= '0;
            pq_rd_q       <= '0;
            ff_wr_q       <= '0;
            ff_rd_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pq_pc_q[i]   <= '0;
                ff_inst_q[i] <= '0;
                ff_pc_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            pend_cnt_q    <= pend_cnt_d;
            out_cnt_q     <= out_cnt_d;
            discard_cnt_q <= discard_cnt_d;
            pq_wr_q       <= pq_wr_d;
            pq_rd_q       <= pq_rd_d;
            ff_wr_q       <= ff_wr_d;
            ff_rd_q       <= ff_rd_d;
            pq_pc_q       <= pq_pc_d;
            ff_inst_q     <= ff_inst_d;
            ff_pc_q       <= ff_pc_d;
        end
    end

    assign bus.imem_req_o   = req;
    assign bus.imem_addr_o  = {bus.pc_i[AW-1:2], 2'b00};
    assign bus.pc_ready_o   = accept;
    assign bus.inst_valid_o = (out_cnt_q != '0);
    assign bus.inst_o       = ff_inst_q[ff_rd_q];
    assign bus.inst_pc_o    = ff_pc_q[ff_rd_q];
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed scoreboard bench for if_fetch_queue
module tb_if_fetch_queue;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_fetch_queue_if #(.AW(32)) bus ();

    if_fetch_queue #(.DEPTH(4), .AW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb_pend[$];
    ent_t        sb_exp[$];
    bit          m_drain  = 0;
    int          m_discard = 0;
    bit          auto_mem = 0;
    bit          auto_pc  = 0;
    bit          last_acc, last_req;
    logic [31:0] last_addr;
    int          acc_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drain_rsp();
        if (bus.imem_rvalid_i && sb_pend.size() > 0) begin
            void'(sb_pend.pop_front());
            m_discard--;
            if (m_discard == 0) m_drain = 0;
        end
    endtask

    // One clock: compare at negedge against the model, advance the model, step past posedge.
    task automatic tick();
        bit          exp_req, m_acc;
        ent_t        e;
        logic [31:0] acc_pc;
        @(negedge clk);
        check("inst_valid", bus.inst_valid_o, sb_exp.size() != 0);
        if (sb_exp.size() != 0) begin
            check("inst_o", bus.inst_o, sb_exp[0].inst);
            check("inst_pc_o", bus.inst_pc_o, sb_exp[0].pc);
        end
        exp_req = bus.pc_valid_i && !bus.flush_i && !m_drain &&
                  (sb_pend.size() + sb_exp.size() < 4);
        m_acc   = exp_req && bus.imem_gnt_i;
        acc_pc  = bus.pc_i;
        check("imem_req_o", bus.imem_req_o, exp_req);
        check("pc_ready_o", bus.pc_ready_o, m_acc);
        if (exp_req) check("imem_addr_o", bus.imem_addr_o, {bus.pc_i[31:2], 2'b00});
        last_acc  = bus.pc_ready_o;
        last_req  = bus.imem_req_o;
        last_addr = bus.imem_addr_o;
        if (bus.flush_i && !m_drain) begin
            if (bus.imem_rvalid_i && sb_pend.size() > 0) void'(sb_pend.pop_front());
            sb_exp.delete();
            m_discard = sb_pend.size();
            m_drain   = (m_discard > 0);
        end else if (m_drain) begin
            drain_rsp();
        end else begin
            if (sb_exp.size() != 0 && bus.inst_ready_i) void'(sb_exp.pop_front());
            if (bus.imem_rvalid_i && sb_pend.size() > 0) begin
                e.pc   = sb_pend.pop_front();
                e.inst = bus.imem_rdata_i;
                sb_exp.push_back(e);
            end
            if (m_acc) sb_pend.push_back(acc_pc);
        end
        @(posedge clk);
        #1;
        if (auto_mem) begin
            bus.imem_rvalid_i = m_acc;
            bus.imem_rdata_i  = 32'hA500_0000 ^ acc_pc;
        end
        if (auto_pc && m_acc) bus.pc_i = bus.pc_i + 32'd4;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.pc_i          = '0;
        bus.pc_valid_i    = 1'b1;
        bus.imem_gnt_i    = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.inst_ready_i  = 1'b0;
        bus.flush_i       = 1'b0;

        // Reset state, with a valid PC and grant offered
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_inst_valid", bus.inst_valid_o, 1'b0);
        check("rst_imem_req", bus.imem_req_o, 1'b0);
        check("rst_pc_ready", bus.pc_ready_o, 1'b0);
        check("rst_inst_o", bus.inst_o, 32'h0);
        check("rst_inst_pc", bus.inst_pc_o, 32'h0);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.pc_valid_i = 1'b0;
        tick();

        // Basic stream: one-cycle response, decode always ready
        bus.inst_ready_i = 1'b1;
        bus.pc_valid_i = 1'b1; bus.pc_i = 32'h0;
        tick();
        bus.pc_i = 32'h4; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h2008_0001;
        tick();
        check("t1_inst0", bus.inst_o, 32'h2008_0001);
        check("t1_pc0", bus.inst_pc_o, 32'h0);
        bus.pc_i = 32'h8; bus.imem_rdata_i = 32'h2009_0002;
        tick();
        check("t1_inst1", bus.inst_o, 32'h2009_0002);
        bus.pc_valid_i = 1'b0; bus.imem_rdata_i = 32'h200A_0003;
        tick();
        check("t1_inst2", bus.inst_o, 32'h200A_0003);
        check("t1_pc2", bus.inst_pc_o, 32'h8);
        bus.imem_rvalid_i = 1'b0;
        repeat (2) tick();

        // Credit limit: decode stalled, exactly DEPTH requests accepted
        bus.inst_ready_i = 1'b0;
        bus.pc_i = 32'h0; bus.pc_valid_i = 1'b1;
        auto_mem = 1; auto_pc = 1; acc_cnt = 0;
        repeat (7) begin
            tick();
            acc_cnt += int'(last_acc);
        end
        check("t2_acc_cnt", acc_cnt, 4);
        check("t2_full_valid", bus.inst_valid_o, 1'b1);
        check("t2_head_pc", bus.inst_pc_o, 32'h0);
        bus.inst_ready_i = 1'b1;
        tick();
        bus.inst_ready_i = 1'b0;
        tick();
        check("t2_refill_acc", last_acc, 1'b1);
        check("t2_refill_addr", last_addr, 32'h10);
        tick();
        bus.pc_valid_i = 1'b0; bus.inst_ready_i = 1'b1;
        repeat (8) tick();
        auto_mem = 0; auto_pc = 0;
        bus.imem_rvalid_i = 1'b0;

        // Grant stall holds the request
        bus.pc_i = 32'h40; bus.pc_valid_i = 1'b1; bus.imem_gnt_i = 1'b0;
        repeat (3) begin
            tick();
            check("t3_stall_acc", last_acc, 1'b0);
            check("t3_stall_req", last_req, 1'b1);
            check("t3_stall_addr", last_addr, 32'h40);
        end
        bus.imem_gnt_i = 1'b1;
        tick();
        check("t3_acc", last_acc, 1'b1);
        bus.pc_valid_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0000_0013;
        tick();
        bus.imem_rvalid_i = 1'b0;
        repeat (2) tick();

        // Flush with three in flight: all three responses dropped
        bus.pc_valid_i = 1'b1;
        bus.pc_i = 32'h100; tick();
        bus.pc_i = 32'h104; tick();
        bus.pc_i = 32'h108; tick();
        bus.pc_valid_i = 1'b0; bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("t4_flush_empty", bus.inst_valid_o, 1'b0);
        bus.pc_valid_i = 1'b1; bus.pc_i = 32'h200;
        bus.imem_rvalid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.imem_rdata_i = 32'hDEAD_0000 + i;
            tick();
            check("t4_drain_req", last_req, 1'b0);
        end
        bus.imem_rvalid_i = 1'b0;
        tick();
        check("t4_resume_acc", last_acc, 1'b1);
        check("t4_resume_addr", last_addr, 32'h200);
        bus.pc_valid_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0200_0013;
        tick();
        check("t4_out_pc", bus.inst_pc_o, 32'h200);
        bus.imem_rvalid_i = 1'b0;
        repeat (2) tick();

        // Flush coinciding with a response: only one more is dropped
        bus.pc_valid_i = 1'b1;
        bus.pc_i = 32'h300; tick();
        bus.pc_i = 32'h304; tick();
        bus.pc_valid_i = 1'b0; bus.flush_i = 1'b1;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hBAD0_0300;
        tick();
        bus.flush_i = 1'b0;
        bus.pc_valid_i = 1'b1; bus.pc_i = 32'h310;
        bus.imem_rdata_i = 32'hBAD0_0304;
        tick();
        check("t5_drain_req", last_req, 1'b0);
        bus.imem_rvalid_i = 1'b0;
        tick();
        check("t5_resume_acc", last_acc, 1'b1);
        bus.pc_valid_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0310_0013;
        tick();
        check("t5_out_pc", bus.inst_pc_o, 32'h310);
        bus.imem_rvalid_i = 1'b0;
        repeat (2) tick();

        // Asynchronous reset with two pending and two buffered
        bus.inst_ready_i = 1'b0; bus.pc_valid_i = 1'b1;
        bus.pc_i = 32'h400; tick();
        bus.pc_i = 32'h404; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0400_0013; tick();
        bus.pc_i = 32'h408; bus.imem_rdata_i = 32'h0404_0013; tick();
        bus.pc_i = 32'h40C; bus.imem_rvalid_i = 1'b0; tick();
        bus.pc_i = 32'h410; tick();
        check("t6_pre_valid", bus.inst_valid_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", bus.inst_valid_o, 1'b0);
        check("t6_rst_req", bus.imem_req_o, 1'b0);
        check("t6_rst_pc_ready", bus.pc_ready_o, 1'b0);
        sb_pend.delete();
        sb_exp.delete();
        m_drain = 0;
        bus.pc_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hBAD0_0408;
        tick();
        bus.imem_rvalid_i = 1'b0;
        tick();
        check("t6_stray_valid", bus.inst_valid_o, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
